// File: rtl/common_pseudo_lru_pkg.sv
// common_pseudo_lru_pkg: shared state encodings and sizing helper for the tree-PLRU victim reader.
package common_pseudo_lru_pkg;
  typedef enum logic [1:0] {
    PLRU_V_IDLE = 2'd0,
    PLRU_V_RESP = 2'd1,
    PLRU_V_HOLD = 2'd2
  } plru_v_state_e;
  function automatic int plru_nodes(input int l);
    return (1 << l) - 1;
  endfunction
endpackage

// File: rtl/common_pseudo_lru_tree_state.sv
// common_pseudo_lru_tree_state: tree-PLRU node bits with ordered touch/commit updates and victim walk.
module common_pseudo_lru_tree_state
  import common_pseudo_lru_pkg::*;
#(
  parameter int L = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         touch_en,
  input  logic [L-1:0] touch_addr,
  input  logic         commit_en,
  input  logic [L-1:0] commit_addr,
  input  logic         bypass,
  output logic [L-1:0] victim
);
  localparam int N = plru_nodes(L);
  logic [N-1:0] tree_q, mid, tree_d;
  // Nodes on way a's path are pointed away from a; node k's children are 2k+1 and 2k+2.
  function automatic logic [N-1:0] upd(input logic [N-1:0] t, input logic [L-1:0] a);
    int k;
    k = 0;
    for (int i = 0; i < L; i++) begin
      t[k] = ~a[L-1-i];
      k = 2 * k + 1 + int'(a[L-1-i]);
    end
    return t;
  endfunction
  function automatic logic [L-1:0] walk(input logic [N-1:0] t);
    logic [L-1:0] v;
    int k;
    k = 0;
    v = '0;
    for (int i = 0; i < L; i++) begin
      v[L-1-i] = t[k];
      k = 2 * k + 1 + int'(t[k]);
    end
    return v;
  endfunction
  always_comb begin
    mid    = touch_en ? upd(tree_q, touch_addr) : tree_q;
    tree_d = commit_en ? upd(mid, commit_addr) : mid;
    victim = walk(bypass ? mid : tree_q);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) tree_q <= '0;
    else tree_q <= tree_d;
endmodule

// File: rtl/common_pseudo_lru_tree_victim_binrd.sv
// common_pseudo_lru_tree_victim_binrd: hands out and holds one binary PLRU victim per request.
// Define COMMON_PSEUDO_LRU_TOUCH_BYPASS_EN to let a same-cycle touch steer the victim walk.
module common_pseudo_lru_tree_victim_binrd
  import common_pseudo_lru_pkg::*;
#(
  parameter int SUBJECT_COUNT_LOG2 = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [SUBJECT_COUNT_LOG2-1:0] touch_addr,
  input  logic                          touch_en,
  input  logic                          vreq_valid,
  output logic                          vreq_ready,
  output logic                          vresp_valid,
  input  logic                          vresp_ready,
  output logic [SUBJECT_COUNT_LOG2-1:0] vresp_addr,
  input  logic                          commit,
  input  logic                          abort,
  output logic                          busy
);
  localparam int L = SUBJECT_COUNT_LOG2;
  plru_v_state_e state_q;
  logic [L-1:0] addr_q, victim;
  logic         bypass, commit_en;
`ifdef COMMON_PSEUDO_LRU_TOUCH_BYPASS_EN
  assign bypass = 1'b1;
`else
  assign bypass = 1'b0;
`endif
  assign commit_en = (state_q == PLRU_V_HOLD) && commit;
  common_pseudo_lru_tree_state #(.L(L)) u_tree (
    .clk        (clk),
    .resetn     (resetn),
    .touch_en   (touch_en),
    .touch_addr (touch_addr),
    .commit_en  (commit_en),
    .commit_addr(addr_q),
    .bypass     (bypass),
    .victim     (victim)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= PLRU_V_IDLE;
      addr_q  <= '0;
    end else begin
      case (state_q)
        PLRU_V_IDLE: if (vreq_valid) begin
          state_q <= PLRU_V_RESP;
          addr_q  <= victim;
        end
        PLRU_V_RESP: if (vresp_ready) state_q <= PLRU_V_HOLD;
        default:     if (commit || abort) state_q <= PLRU_V_IDLE;
      endcase
    end
  assign vreq_ready  = state_q == PLRU_V_IDLE;
  assign vresp_valid = state_q == PLRU_V_RESP;
  assign busy        = state_q != PLRU_V_IDLE;
  assign vresp_addr  = addr_q;
endmodule

// File: tb/tb_common_pseudo_lru_tree_victim_binrd.sv
// tb_common_pseudo_lru_tree_victim_binrd: directed checks of victim handout, commit/abort and touch ordering (N=4).
module tb_common_pseudo_lru_tree_victim_binrd;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] touch_addr = '0;
  logic       touch_en = 1'b0;
  logic       vreq_valid = 1'b0;
  logic       vreq_ready;
  logic       vresp_valid;
  logic       vresp_ready = 1'b0;
  logic [1:0] vresp_addr;
  logic       commit = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  int checks = 0;
  int errors = 0;

  common_pseudo_lru_tree_victim_binrd #(.SUBJECT_COUNT_LOG2(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .touch_addr (touch_addr),
    .touch_en   (touch_en),
    .vreq_valid (vreq_valid),
    .vreq_ready (vreq_ready),
    .vresp_valid(vresp_valid),
    .vresp_ready(vresp_ready),
    .vresp_addr (vresp_addr),
    .commit     (commit),
    .abort      (abort),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    {touch_en, touch_addr, vreq_valid, vresp_ready, commit, abort} = '0;
    resetn = 1'b0;
    step;
    step;
    resetn = 1'b1;
    step;
  endtask

  // Request, check one-cycle latency and the victim, accept it into HOLD.
  task automatic request(input logic [1:0] exp, input string name);
    vreq_valid = 1'b1;
    checks++;
    if (vreq_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b want 1", name, vreq_ready);
    end
    step;
    vreq_valid = 1'b0;
    checks++;
    if (vresp_valid !== 1'b1 || vresp_addr !== exp) begin
      errors++;
      $display("FAIL %s_victim: got valid=%b addr=%0d want valid=1 addr=%0d", name, vresp_valid, vresp_addr, exp);
    end
    vresp_ready = 1'b1;
    step;
    vresp_ready = 1'b0;
    checks++;
    if (vresp_valid !== 1'b0 || busy !== 1'b1 || vresp_addr !== exp) begin
      errors++;
      $display("FAIL %s_hold: got valid=%b busy=%b addr=%0d want 0 1 %0d", name, vresp_valid, busy, vresp_addr, exp);
    end
  endtask

  task automatic finish_victim(input logic c, input logic a, input string name);
    commit = c;
    abort = a;
    step;
    commit = 1'b0;
    abort = 1'b0;
    checks++;
    if (vreq_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: got ready=%b busy=%b want 1 0", name, vreq_ready, busy);
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({vreq_ready, vresp_valid, vresp_addr, busy} !== 5'b1_0_00_0) begin
      errors++;
      $display("FAIL reset: got ready=%b valid=%b addr=%0d busy=%b want 1 0 0 0", vreq_ready, vresp_valid, vresp_addr, busy);
    end
    request(2'd0, "first");
    finish_victim(1'b0, 1'b1, "first");
  endtask

  task automatic test_commit_sequence;
    do_reset;
    request(2'd0, "seq0");
    finish_victim(1'b1, 1'b0, "seq0");
    request(2'd2, "seq2");
    finish_victim(1'b1, 1'b0, "seq2");
    request(2'd1, "seq1");
    finish_victim(1'b1, 1'b0, "seq1");
    request(2'd3, "seq3");
    finish_victim(1'b1, 1'b0, "seq3");
    request(2'd0, "seq_wrap");
    finish_victim(1'b0, 1'b1, "seq_wrap");
  endtask

  task automatic test_abort;
    do_reset;
    request(2'd0, "abort_a");
    finish_victim(1'b0, 1'b1, "abort_a");
    request(2'd0, "abort_b");
    finish_victim(1'b0, 1'b1, "abort_b");
  endtask

  task automatic test_touch_commit;
    do_reset;
    request(2'd0, "tc");
    touch_en = 1'b1;
    touch_addr = 2'd2;
    finish_victim(1'b1, 1'b0, "tc");
    touch_en = 1'b0;
    request(2'd3, "tc_next");
    finish_victim(1'b0, 1'b1, "tc_next");
  endtask

  task automatic test_bypass;
    logic [1:0] exp;
`ifdef COMMON_PSEUDO_LRU_TOUCH_BYPASS_EN
    exp = 2'd2;
`else
    exp = 2'd0;
`endif
    do_reset;
    touch_en = 1'b1;
    touch_addr = 2'd0;
    request(exp, "bypass");
    touch_en = 1'b0;
    finish_victim(1'b0, 1'b1, "bypass");
    request(2'd2, "bypass_after");
    finish_victim(1'b0, 1'b1, "bypass_after");
  endtask

  task automatic test_resp_stall_touch;
    do_reset;
    vreq_valid = 1'b1;
    step;
    vreq_valid = 1'b0;
    touch_en = 1'b1;
    touch_addr = 2'd0;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if (vresp_valid !== 1'b1 || vresp_addr !== 2'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_%0d: got valid=%b addr=%0d busy=%b want 1 0 1", i, vresp_valid, vresp_addr, busy);
      end
    end
    touch_en = 1'b0;
    vresp_ready = 1'b1;
    step;
    vresp_ready = 1'b0;
    finish_victim(1'b0, 1'b1, "stall");
    request(2'd2, "stall_next");
    finish_victim(1'b0, 1'b1, "stall_next");
  endtask

  task automatic test_ignore_and_priority;
    do_reset;
    commit = 1'b1;
    step;
    commit = 1'b0;
    request(2'd0, "idle_commit");
    finish_victim(1'b1, 1'b1, "both");
    request(2'd2, "both_next");
    finish_victim(1'b0, 1'b1, "both_next");
  endtask

  task automatic test_back_to_back;
    do_reset;
    request(2'd0, "b2b");
    commit = 1'b1;
    vreq_valid = 1'b1;
    step;
    commit = 1'b0;
    checks++;
    if (vresp_valid !== 1'b0 || vreq_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_reaccept: got valid=%b ready=%b want 0 1", vresp_valid, vreq_ready);
    end
    step;
    vreq_valid = 1'b0;
    checks++;
    if (vresp_valid !== 1'b1 || vresp_addr !== 2'd2) begin
      errors++;
      $display("FAIL b2b_accept: got valid=%b addr=%0d want 1 2", vresp_valid, vresp_addr);
    end
    vresp_ready = 1'b1;
    step;
    vresp_ready = 1'b0;
    finish_victim(1'b0, 1'b1, "b2b");
  endtask

  task automatic test_reset_mid;
    do_reset;
    request(2'd0, "rst_mid");
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, vresp_valid, vreq_ready, vresp_addr} !== 5'b0_0_1_00) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b valid=%b ready=%b addr=%0d want 0 0 1 0", busy, vresp_valid, vreq_ready, vresp_addr);
    end
    step;
    resetn = 1'b1;
    step;
    commit = 1'b1;
    step;
    commit = 1'b0;
    request(2'd0, "rst_after");
    finish_victim(1'b0, 1'b1, "rst_after");
  endtask

  initial begin
    test_reset;
    test_commit_sequence;
    test_abort;
    test_touch_commit;
    test_bypass;
    test_resp_stall_touch;
    test_ignore_and_priority;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
